// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module : usr_pkg
// Brief  : Shared types and select encodings for the usr_shift_seq block.
// Rev    : 1.0
// ============================================================================
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SHL  = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/iiitb_usr.sv
`default_nettype none
// ============================================================================
// Module : iiitb_usr
// Brief  : Universal shift register: shift left, shift right, load, hold.
// Rev    : 1.0
// ============================================================================
module iiitb_usr
  import usr_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [1:0]     i_select,
  input  logic [MSB-1:0] i_data_in,
  output logic [MSB-1:0] o_data_out
);

  logic [MSB-1:0] r_data;

  // Left shifts fill from data_in[0], right shifts fill from data_in[MSB-1].
  always_ff @(posedge clock) begin
    if (clear) begin
      r_data <= '0;
    end else begin
      case (i_select)
        SEL_SHL:  r_data <= {r_data[MSB-2:0], i_data_in[0]};
        SEL_SHR:  r_data <= {i_data_in[MSB-1], r_data[MSB-1:1]};
        SEL_LOAD: r_data <= i_data_in;
        default:  r_data <= r_data;
      endcase
    end
  end

  assign o_data_out = r_data;

endmodule
`default_nettype wire

// File: rtl/usr_shift_seq.sv
`default_nettype none
// ============================================================================
// Module : usr_shift_seq
// Brief  : Full-duplex serial engine sequencing one iiitb_usr shift register.
// Rev    : 1.0
// ============================================================================
module usr_shift_seq
  import usr_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [MSB-1:0] load_data,
  input  logic           dir,
  output logic           ser_out,
  output logic           ser_valid,
  input  logic           ser_ready,
  input  logic           ser_in,
  output logic [MSB-1:0] rx_data,
  output logic           rx_valid,
  input  logic           rx_ready,
  output logic           busy
);

  localparam int CW = $clog2(MSB);
  localparam logic [CW-1:0] C_LAST = CW'(MSB - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_dir;
  logic [1:0]      w_sel;
  logic [MSB-1:0]  w_din;
  logic [MSB-1:0]  w_q;
  logic            w_start;
  logic            w_beat;

  assign w_start = start_valid & start_ready;
  assign w_beat  = (r_state == SHIFT) & ser_ready;

  // Serial bit is replicated so either fill position of the register sees it.
  always_comb begin
    w_sel = SEL_HOLD;
    w_din = load_data;
    case (r_state)
      IDLE: begin
        if (w_start) w_sel = SEL_LOAD;
      end
      SHIFT: begin
        if (ser_ready) begin
          w_sel = r_dir ? SEL_SHR : SEL_SHL;
          w_din = {MSB{ser_in}};
        end
      end
      default: w_sel = SEL_HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_dir   <= dir;
          end
        end
        SHIFT: begin
          if (w_beat) begin
            if (r_cnt == C_LAST) begin
              r_state <= DONE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (rx_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  iiitb_usr #(
    .MSB(MSB)
  ) u_usr (
    .clock      (clock),
    .clear      (clear),
    .i_select   (w_sel),
    .i_data_in  (w_din),
    .o_data_out (w_q)
  );

  assign start_ready = (r_state == IDLE) & ~clear;
  assign ser_valid   = (r_state == SHIFT);
  assign ser_out     = r_dir ? w_q[0] : w_q[MSB-1];
  assign rx_valid    = (r_state == DONE);
  assign rx_data     = w_q;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usr_shift_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_usr_shift_seq
// Brief  : Scoreboard bench for usr_shift_seq with a word-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_usr_shift_seq;

  localparam int MSB = 8;

  logic           clock = 1'b0;
  logic           clear;
  logic           start_valid;
  logic           start_ready;
  logic [MSB-1:0] load_data;
  logic           dir;
  logic           ser_out;
  logic           ser_valid;
  logic           ser_ready;
  logic           ser_in;
  logic [MSB-1:0] rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic           busy;

  int errors = 0;
  int checks = 0;

  logic           exp_ser[$];
  logic [MSB-1:0] exp_rx[$];
  logic [MSB-1:0] cur_sin;

  usr_shift_seq #(.MSB(MSB)) dut (
    .clock       (clock),
    .clear       (clear),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .load_data   (load_data),
    .dir         (dir),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .ser_ready   (ser_ready),
    .ser_in      (ser_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the queues whenever they are presented.
  always @(negedge clock) begin
    if (!clear) begin
      if (ser_valid) begin
        check("ser_expected", 32'(exp_ser.size() != 0), 32'd1);
        if (exp_ser.size() != 0) begin
          check("ser_out", 32'(ser_out), 32'(exp_ser[0]));
          if (ser_ready) void'(exp_ser.pop_front());
        end
      end
      if (rx_valid) begin
        check("rx_expected", 32'(exp_rx.size() != 0), 32'd1);
        if (exp_rx.size() != 0) begin
          check("rx_data", 32'(rx_data), 32'(exp_rx[0]));
          if (rx_ready) void'(exp_rx.pop_front());
        end
      end
    end
  end

  // Reference model: word-level view of what goes out and what comes back.
  task automatic push_model(input logic [MSB-1:0] w, input logic d,
                            input logic [MSB-1:0] sin, input bit loopback);
    logic [MSB-1:0] outb;
    logic [MSB-1:0] rx;
    for (int i = 0; i < MSB; i++) outb[i] = d ? w[i] : w[MSB-1-i];
    if (loopback) sin = outb;
    rx = '0;
    for (int i = 0; i < MSB; i++) begin
      if (d) rx[i] = sin[i];
      else   rx[MSB-1-i] = sin[i];
    end
    for (int i = 0; i < MSB; i++) exp_ser.push_back(outb[i]);
    exp_rx.push_back(rx);
    cur_sin = sin;
  endtask

  task automatic start_word(input logic [MSB-1:0] w, input logic d,
                            input logic [MSB-1:0] sin, input bit loopback);
    bit acc = 0;
    push_model(w, d, sin, loopback);
    start_valid = 1'b1;
    load_data   = w;
    dir         = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (start_ready) begin
        @(posedge clock); #1;
        acc = 1;
        break;
      end
      @(posedge clock); #1;
    end
    start_valid = 1'b0;
    check("start_accepted", 32'(acc), 32'd1);
  endtask

  task automatic shift_bits(input int stall_after, input int stall_len, input bit rnd,
                            input int nbits, output int cycles);
    int  k = 0;
    int  stalled = 0;
    bit  acc;
    cycles = 0;
    for (int n = 0; n < 300 && k < nbits; n++) begin
      if (rnd)                                         ser_ready = 1'($urandom_range(0, 1));
      else if (k == stall_after && stalled < stall_len) ser_ready = 1'b0;
      else                                             ser_ready = 1'b1;
      ser_in = cur_sin[k];
      @(negedge clock);
      if (ser_valid) cycles++;
      if (!ser_ready) stalled++;
      acc = ser_valid && ser_ready;
      @(posedge clock); #1;
      if (acc) k++;
    end
    ser_ready = 1'b0;
    check("shift_beats", 32'(k), 32'(nbits));
  endtask

  task automatic finish_rx(input int hold, input bit extra_start);
    bit got = 0;
    rx_ready    = 1'b0;
    start_valid = extra_start;
    load_data   = 8'h99;
    for (int n = 0; n < hold; n++) begin
      @(negedge clock);
      check("done_start_ready", 32'(start_ready), 32'd0);
      check("done_rx_valid", 32'(rx_valid), 32'd1);
      @(posedge clock); #1;
    end
    start_valid = 1'b0;
    rx_ready    = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (rx_valid) begin
        @(posedge clock); #1;
        got = 1;
        break;
      end
      @(posedge clock); #1;
    end
    rx_ready = 1'b0;
    check("rx_handshake", 32'(got), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [MSB-1:0] w;
    clear = 1'b1; start_valid = 1'b0; load_data = '0; dir = 1'b0;
    ser_ready = 1'b0; ser_in = 1'b0; rx_ready = 1'b0; cur_sin = '0;

    // Reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_start_ready", 32'(start_ready), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    check("post_reset_ser_valid", 32'(ser_valid), 32'd0);
    check("post_reset_rx_valid", 32'(rx_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_start_ready", 32'(start_ready), 32'd1);
    check("post_reset_rx_data", 32'(rx_data), 32'd0);
    @(posedge clock); #1;

    // 0xA5, MSB first, ser_in 0,0,1,1,1,1,0,0
    start_word(8'hA5, 1'b0, 8'h3C, 1'b0);
    shift_bits(-1, 0, 1'b0, MSB, cyc);
    check("t1_shift_cycles", 32'(cyc), 32'd8);
    @(negedge clock);
    check("t1_rx_valid_latency", 32'(rx_valid), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'h3C);
    @(posedge clock); #1;
    finish_rx(0, 1'b0);

    // 0x01, LSB first, first received bit 1
    start_word(8'h01, 1'b1, 8'h01, 1'b0);
    shift_bits(-1, 0, 1'b0, MSB, cyc);
    finish_rx(0, 1'b0);

    // Loopback 0x5E
    start_word(8'h5E, 1'b0, 8'h00, 1'b1);
    shift_bits(-1, 0, 1'b0, MSB, cyc);
    finish_rx(1, 1'b0);

    // Backpressure: 3 stall cycles after bit 2
    start_word(8'hF0, 1'b0, 8'hA6, 1'b0);
    shift_bits(2, 3, 1'b0, MSB, cyc);
    check("t4_shift_cycles", 32'(cyc), 32'd11);
    finish_rx(0, 1'b0);

    // Clear after the 4th accepted bit
    start_word(8'hC3, 1'b0, 8'h5A, 1'b0);
    shift_bits(-1, 0, 1'b0, 4, cyc);
    clear = 1'b1;
    @(negedge clock);
    check("clear_start_ready", 32'(start_ready), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    exp_ser.delete();
    exp_rx.delete();
    @(negedge clock);
    check("clear_busy", 32'(busy), 32'd0);
    check("clear_rx_valid", 32'(rx_valid), 32'd0);
    check("clear_rx_data", 32'(rx_data), 32'd0);
    check("clear_start_ready_after", 32'(start_ready), 32'd1);
    check("clear_ser_valid", 32'(ser_valid), 32'd0);
    repeat (12) @(posedge clock);
    #1;

    // Extra start_valid and rx_ready low for 5 cycles in DONE
    start_word(8'h3A, 1'b1, 8'hE1, 1'b0);
    shift_bits(-1, 0, 1'b0, MSB, cyc);
    finish_rx(5, 1'b1);
    @(negedge clock);
    check("extra_start_ignored_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;

    // rx_ready and start_valid together in DONE
    start_word(8'h96, 1'b0, 8'h0F, 1'b0);
    shift_bits(-1, 0, 1'b0, MSB, cyc);
    push_model(8'h4B, 1'b1, 8'hB2, 1'b0);
    rx_ready = 1'b1; start_valid = 1'b1; load_data = 8'h4B; dir = 1'b1;
    @(negedge clock);
    check("same_cycle_rx_valid", 32'(rx_valid), 32'd1);
    check("same_cycle_start_ready", 32'(start_ready), 32'd0);
    @(posedge clock); #1;
    rx_ready = 1'b0;
    @(negedge clock);
    check("one_later_start_ready", 32'(start_ready), 32'd1);
    @(posedge clock); #1;
    start_valid = 1'b0;
    @(negedge clock);
    check("one_later_ser_valid", 32'(ser_valid), 32'd1);
    @(posedge clock); #1;
    shift_bits(-1, 0, 1'b0, MSB, cyc);
    finish_rx(0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 25; t++) begin
      w = MSB'($urandom);
      start_word(w, 1'($urandom_range(0, 1)), MSB'($urandom), 1'($urandom_range(0, 3) == 0));
      shift_bits(-1, 0, 1'b1, MSB, cyc);
      finish_rx(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("ser_queue_drained", 32'(exp_ser.size()), 32'd0);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
